// File: rtl/integer_multiplier_pkg.sv
// Shared state encodings and default operand width for the shift-and-add multiplier.
package mult_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/integer_multiplier_datapath.sv
// Datapath for the shift-and-add multiplier: multiplicand, carry-extended accumulator,
// shifting multiplier, iteration counter and the product register.
module shift_add_datapath
    import mult_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld,
    input  logic           add,
    input  logic           shr,
    input  logic           ldp,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p,
    output logic           q0,
    output logic           cnt_is_1
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]   m_q,   m_d;
    logic [W:0]     acc_q, acc_d;
    logic [W-1:0]   q_q,   q_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] p_q,   p_d;
    logic [2*W:0]   shifted;

    // The product register captures the post-shift value, so it is fed from the
    // same shifted word that updates {A,Q} in the final SHIFT cycle.
    always_comb begin
        shifted = {acc_q, q_q} >> 1;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        if (ld) begin
            m_d   = a;
            q_d   = b;
            acc_d = '0;
            cnt_d = CW'(W);
        end else if (add) begin
            acc_d = acc_q + {1'b0, m_q};
        end else if (shr) begin
            acc_d = shifted[2*W:W];
            q_d   = shifted[W-1:0];
            cnt_d = cnt_q - 1'b1;
        end
        if (ldp) begin
            p_d = shifted[2*W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            acc_q <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            p_q   <= '0;
        end else begin
            m_q   <= m_d;
            acc_q <= acc_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
            p_q   <= p_d;
        end
    end

    assign p        = p_q;
    assign q0       = q_q[0];
    assign cnt_is_1 = (cnt_q == CW'(1));

endmodule

// File: rtl/integer_multiplier.sv
// Sequential unsigned shift-and-add multiplier: control FSM, status decode and the
// datapath instance.
module integer_multiplier
    import mult_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p,
    output logic           done,
    output logic           busy,
    output logic [2:0]     CS
);

    state_e state_q, state_d;
    logic   ld, add, shr, ldp;
    logic   q0, cnt_is_1;

    // Unused encodings fall back to IDLE through the default arm.
    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        add     = 1'b0;
        shr     = 1'b0;
        ldp     = 1'b0;
        case (state_q)
            IDLE:    if (go) state_d = LOAD;
            LOAD: begin
                ld      = 1'b1;
                state_d = TEST;
            end
            TEST:    state_d = q0 ? ADD : SHIFT;
            ADD: begin
                add     = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                shr = 1'b1;
                if (cnt_is_1) begin
                    ldp     = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = TEST;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign done = (state_q == DONE);
    assign busy = (state_q != IDLE);
    assign CS   = state_q;

    shift_add_datapath #(
        .W(W)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .add      (add),
        .shr      (shr),
        .ldp      (ldp),
        .a        (a),
        .b        (b),
        .p        (p),
        .q0       (q0),
        .cnt_is_1 (cnt_is_1)
    );

endmodule

// File: tb/tb_integer_multiplier.sv
// Directed bench for integer_multiplier at W=4 and W=1 with hand-computed products
// and cycle counts.
module tb_integer_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic       go4, go1;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic       done4, busy4;
    logic [2:0] cs4;
    logic [0:0] a1, b1;
    logic [1:0] p1;
    logic       done1, busy1;
    logic [2:0] cs1;

    int tests  = 0;
    int failed = 0;

    int         done_cyc, busy_err;
    logic       busy_pre, busy_post, done_post;
    logic [7:0] p_done, p_pre;
    logic [2:0] cs_log [0:47];

    integer_multiplier #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .go(go4), .a(a4), .b(b4),
        .p(p4), .done(done4), .busy(busy4), .CS(cs4)
    );

    integer_multiplier #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .go(go1), .a(a1), .b(b1),
        .p(p1), .done(done1), .busy(busy1), .CS(cs1)
    );

    always #5 clk = ~clk;

    // Called at a negedge while the W=4 unit is idle; that cycle is cycle 0.
    // mode 0 pulses go, mode 1 holds it high, mode 2 toggles it every cycle.
    task automatic run4(input logic [3:0] ai, input logic [3:0] bi, input int mode);
        a4 = ai;
        b4 = bi;
        go4 = 1'b1;
        busy_pre = busy4;
        done_cyc = -1;
        busy_err = 0;
        p_pre = 'x;
        cs_log[0] = cs4;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (mode == 0) go4 = 1'b0;
            else if (mode == 2) go4 = ~go4;
            if (c >= 2) begin
                a4 = ~ai;
                b4 = ~bi;
            end
            cs_log[c] = cs4;
            if (busy4 !== 1'b1) busy_err++;
            if (done4 === 1'b1) begin
                done_cyc = c;
                p_done = p4;
            end else begin
                p_pre = p4;
            end
        end
        @(negedge clk);
        if (done_cyc >= 0) cs_log[done_cyc + 1] = cs4;
        busy_post = busy4;
        done_post = done4;
        if (mode != 1) go4 = 1'b0;
    endtask

    task automatic run1(input logic [0:0] ai, input logic [0:0] bi,
                        output int dc, output logic [1:0] pd);
        a1 = ai;
        b1 = bi;
        go1 = 1'b1;
        dc = -1;
        pd = 'x;
        for (int c = 1; c <= 20 && dc < 0; c++) begin
            @(negedge clk);
            go1 = 1'b0;
            if (done1 === 1'b1) begin
                dc = c;
                pd = p1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        go4 = 1'b0; a4 = '0; b4 = '0;
        go1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        tests++; if (cs4 !== 3'd0) begin failed++; $display("[TB] FAIL reset_cs: got %0d, expected 0", cs4); end
        tests++; if (busy4 !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy4); end
        tests++; if (done4 !== 1'b0) begin failed++; $display("[TB] FAIL reset_done: got %b, expected 0", done4); end
        tests++; if (p4 !== 8'h00) begin failed++; $display("[TB] FAIL reset_p: got %h, expected 00", p4); end
        tests++; if (cs1 !== 3'd0 || p1 !== 2'b00) begin failed++; $display("[TB] FAIL reset_w1: got cs=%0d p=%b, expected cs=0 p=00", cs1, p1); end
        rst = 1'b0;
    endtask

    task automatic test_zero_multiplier();
        run4(4'h9, 4'h0, 0);
        tests++; if (busy_pre !== 1'b0) begin failed++; $display("[TB] FAIL zero_busy_c0: got %b, expected 0", busy_pre); end
        tests++; if (done_cyc !== 10) begin failed++; $display("[TB] FAIL zero_done_cycle: got %0d, expected 10", done_cyc); end
        tests++; if (p_done !== 8'h00) begin failed++; $display("[TB] FAIL zero_p: got %h, expected 00", p_done); end
        tests++; if (busy_err !== 0) begin failed++; $display("[TB] FAIL zero_busy_window: got %0d low cycles, expected 0", busy_err); end
        tests++; if (busy_post !== 1'b0 || done_post !== 1'b0) begin failed++; $display("[TB] FAIL zero_after: got busy=%b done=%b, expected 0 0", busy_post, done_post); end
    endtask

    task automatic test_carry();
        run4(4'hF, 4'hF, 0);
        tests++; if (done_cyc !== 14) begin failed++; $display("[TB] FAIL carry_done_cycle: got %0d, expected 14", done_cyc); end
        tests++; if (p_done !== 8'hE1) begin failed++; $display("[TB] FAIL carry_p: got %h, expected e1", p_done); end
    endtask

    task automatic test_cs_sequence();
        logic [2:0] exp_cs [14] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4,
                                    3'd2, 3'd4, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        run4(4'hD, 4'hB, 0);
        tests++; if (done_cyc !== 13) begin failed++; $display("[TB] FAIL seq_done_cycle: got %0d, expected 13", done_cyc); end
        tests++; if (p_done !== 8'h8F) begin failed++; $display("[TB] FAIL seq_p: got %h, expected 8f", p_done); end
        for (int c = 1; c <= 14; c++) begin
            tests++;
            if (cs_log[c] !== exp_cs[c-1]) begin
                failed++;
                $display("[TB] FAIL seq_cs_c%0d: got %0d, expected %0d", c, cs_log[c], exp_cs[c-1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run4(4'h3, 4'h5, 1);
        tests++; if (done_cyc !== 12) begin failed++; $display("[TB] FAIL b2b_first_cycle: got %0d, expected 12", done_cyc); end
        tests++; if (p_done !== 8'h0F) begin failed++; $display("[TB] FAIL b2b_first_p: got %h, expected 0f", p_done); end
        tests++; if (cs_log[13] !== 3'd0) begin failed++; $display("[TB] FAIL b2b_idle_gap: got %0d, expected 0", cs_log[13]); end
        run4(4'h7, 4'h2, 1);
        go4 = 1'b0;
        tests++; if (cs_log[1] !== 3'd1) begin failed++; $display("[TB] FAIL b2b_reload: got %0d, expected 1", cs_log[1]); end
        tests++; if (p_pre !== 8'h0F) begin failed++; $display("[TB] FAIL b2b_p_hold: got %h, expected 0f", p_pre); end
        tests++; if (done_cyc !== 11) begin failed++; $display("[TB] FAIL b2b_second_cycle: got %0d, expected 11", done_cyc); end
        tests++; if (p_done !== 8'h0E) begin failed++; $display("[TB] FAIL b2b_second_p: got %h, expected 0e", p_done); end
    endtask

    task automatic test_go_ignored();
        run4(4'h3, 4'h5, 2);
        tests++; if (done_cyc !== 12) begin failed++; $display("[TB] FAIL toggle_done_cycle: got %0d, expected 12", done_cyc); end
        tests++; if (p_done !== 8'h0F) begin failed++; $display("[TB] FAIL toggle_p: got %h, expected 0f", p_done); end
        repeat (2) @(negedge clk);
        tests++; if (cs4 !== 3'd0) begin failed++; $display("[TB] FAIL toggle_no_queue: got %0d, expected 0", cs4); end
    endtask

    task automatic test_reset_mid_op();
        int pulses = 0;
        tests++; if (p4 !== 8'h0F) begin failed++; $display("[TB] FAIL abort_p_before: got %h, expected 0f", p4); end
        a4 = 4'hF;
        b4 = 4'hF;
        go4 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            go4 = 1'b0;
            if (c == 5) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        tests++; if (cs4 !== 3'd0 || busy4 !== 1'b0) begin failed++; $display("[TB] FAIL abort_state: got cs=%0d busy=%b, expected 0 0", cs4, busy4); end
        tests++; if (p4 !== 8'h00) begin failed++; $display("[TB] FAIL abort_p_cleared: got %h, expected 00", p4); end
        for (int c = 0; c < 20; c++) begin
            if (done4 === 1'b1) pulses++;
            @(negedge clk);
        end
        tests++; if (pulses !== 0) begin failed++; $display("[TB] FAIL abort_no_done: got %0d pulses, expected 0", pulses); end
        run4(4'h2, 4'h3, 0);
        tests++; if (done_cyc !== 12) begin failed++; $display("[TB] FAIL abort_rerun_cycle: got %0d, expected 12", done_cyc); end
        tests++; if (p_done !== 8'h06) begin failed++; $display("[TB] FAIL abort_rerun_p: got %h, expected 06", p_done); end
    endtask

    task automatic test_width_one();
        int         dc;
        logic [1:0] pd;
        run1(1'b1, 1'b1, dc, pd);
        tests++; if (dc !== 5) begin failed++; $display("[TB] FAIL w1_ones_cycle: got %0d, expected 5", dc); end
        tests++; if (pd !== 2'b01) begin failed++; $display("[TB] FAIL w1_ones_p: got %b, expected 01", pd); end
        run1(1'b1, 1'b0, dc, pd);
        tests++; if (dc !== 4) begin failed++; $display("[TB] FAIL w1_zero_cycle: got %0d, expected 4", dc); end
        tests++; if (pd !== 2'b00) begin failed++; $display("[TB] FAIL w1_zero_p: got %b, expected 00", pd); end
    endtask

    initial begin
        test_reset();
        test_zero_multiplier();
        test_carry();
        test_cs_sequence();
        test_back_to_back();
        test_go_ignored();
        test_reset_mid_op();
        test_width_one();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
